pe_rx_buffer: RTL and testbench
===============================

PE_RX_BUFFER -- requirements
Module: pe_rx_buffer

Interface
REQ-001 Parameter NUM_VCS, default 2, number of virtual channels (>=1).
REQ-002 Parameter FLIT_DATA_WIDTH, default 64, flit payload width.
REQ-003 Parameter NUM_USER_RECV_PORTS, default 16, sets DEST_BITS = clog2(NUM_USER_RECV_PORTS).
REQ-004 Parameter FLIT_BUFFER_DEPTH, default 4, per-VC FIFO depth (>=1, any integer); VC_BITS = NUM_VCS>1 ? clog2(NUM_VCS) : 1; FW = 2+FLIT_DATA_WIDTH+DEST_BITS+VC_BITS.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 en  in  1  enable; gates dequeue and credit return only.
REQ-008 flit_in  in  FW  flit from router, format {valid, tail, dest, vc, data}, MSB = valid.
REQ-009 credit_out  out  1+VC_BITS  credit to router, format {valid, vc}.
REQ-010 deq_valid  out  1  a buffered flit is presented to the PE.
REQ-011 deq_ready  in  1  PE accepts presented flit.
REQ-012 deq_flit  out  FW  presented flit, unmodified as received.
REQ-013 occupancy  out  NUM_VCS*clog2(FLIT_BUFFER_DEPTH+1)  per-VC fill count, VC0 in LSBs.
REQ-014 pkt_cnt  out  16  count of tail flits dequeued, wraps 0xFFFF->0.
REQ-015 overflow  out  1  sticky error: flit arrived at full VC FIFO.

Function
REQ-016 Block SHALL hold one FIFO per VC, depth FLIT_BUFFER_DEPTH, first-in first-out within a VC.
REQ-017 Enqueue: when flit_in valid bit = 1, flit SHALL be written into FIFO indexed by its vc field at that rising edge, independent of en.
REQ-018 Written flit SHALL be eligible for dequeue no earlier than the following cycle (1-cycle write-to-read latency).
REQ-019 Write to a VC whose registered count == FLIT_BUFFER_DEPTH SHALL be dropped, count unchanged, overflow set to 1 until reset, even if that VC dequeues in the same cycle.
REQ-020 vc field >= NUM_VCS SHALL be dropped and SHALL set overflow.
REQ-021 Selection: deq_valid SHALL be 1 iff en = 1 and any VC FIFO is non-empty; selected VC = first non-empty VC searching upward (modulo NUM_VCS) from round-robin pointer rr.
REQ-022 deq_flit SHALL be the head of the selected VC, combinationally; 0 when deq_valid = 0.
REQ-023 Dequeue occurs on a cycle with deq_valid = 1 and deq_ready = 1; head popped at that edge, rr <= selected+1 mod NUM_VCS; rr unchanged otherwise.
REQ-024 Simultaneous enqueue and dequeue on same non-full VC SHALL leave count unchanged and preserve order.
REQ-025 At most one dequeue per cycle; on each dequeue, credit_out SHALL be {1, selected vc} in the next cycle only, else 0 (registered, exactly one credit per popped flit).
REQ-026 On dequeue with tail bit = 1, pkt_cnt SHALL increment by 1 at that edge, modulo 2^16.
REQ-027 en = 0: deq_valid = 0, no pop, no credit issued in the following cycle; buffered contents and rr retained; enqueue continues.
REQ-028 occupancy fields SHALL reflect registered counts (post-edge values), range 0..FLIT_BUFFER_DEPTH.

Reset
REQ-029 While rst_n = 0, asynchronously: all FIFOs empty, counts 0, rr = 0, credit_out = 0, pkt_cnt = 0, overflow = 0; deq_valid = 0, deq_flit = 0.
REQ-030 Reset mid-operation SHALL discard all buffered flits and any pending credit; no credit is issued for discarded flits.
REQ-031 First enqueue after rst_n rises is accepted at the first rising edge with rst_n = 1.

Verification
REQ-032 Single flit vc0 data 0xA tail=1 at cycle 0, deq_ready=1 -> deq_valid at cycle 1 with deq_flit data 0xA; credit_out = {1,0} at cycle 2; pkt_cnt = 1.
REQ-033 Fill vc1 with 4 flits (depth 4), deq_ready=0, then 5th vc1 flit -> dropped, occupancy vc1 = 4, overflow = 1 sticky; draining yields exactly the first 4 in order and 4 credits for vc1.
REQ-034 vc0 and vc1 each hold 3 flits, deq_ready=1 constantly -> dequeue order vc0,vc1,vc0,vc1,vc0,vc1, one credit per cycle matching each vc.
REQ-035 en=0 with 2 flits buffered for 5 cycles -> deq_valid=0, credit_out=0 throughout; after en=1 both drain, 2 credits.
REQ-036 Assert rst_n=0 with 3 flits buffered and a credit pending -> credit_out=0 immediately, occupancy 0, no credit after release.
REQ-037 Simultaneous enqueue and dequeue on vc0 at count 2 for 10 cycles -> occupancy vc0 stays 2, FIFO order preserved, 10 credits.

Source files
------------

// File: rtl/pe_rx_buffer.sv
// PE receive buffer: one FIFO per virtual channel, round-robin dequeue toward
// the PE, one registered credit back to the router per popped flit.
module pe_rx_buffer #(
  parameter  int NUM_VCS             = 2,
  parameter  int FLIT_DATA_WIDTH     = 64,
  parameter  int NUM_USER_RECV_PORTS = 16,
  parameter  int FLIT_BUFFER_DEPTH   = 4,
  localparam int DEST_BITS           = $clog2(NUM_USER_RECV_PORTS),
  localparam int VC_BITS             = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
  localparam int FW                  = 2 + FLIT_DATA_WIDTH + DEST_BITS + VC_BITS,
  localparam int CNT_BITS            = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [FW-1:0]               flit_in,
  output logic [VC_BITS:0]            credit_out,
  output logic                        deq_valid,
  input  logic                        deq_ready,
  output logic [FW-1:0]               deq_flit,
  output logic [NUM_VCS*CNT_BITS-1:0] occupancy,
  output logic [15:0]                 pkt_cnt,
  output logic                        overflow
);

  localparam int                    PTR_BITS  = (FLIT_BUFFER_DEPTH > 1) ? $clog2(FLIT_BUFFER_DEPTH) : 1;
  localparam logic [CNT_BITS-1:0]   DEPTH_C   = CNT_BITS'(FLIT_BUFFER_DEPTH);
  localparam logic [PTR_BITS-1:0]   LAST_PTR  = PTR_BITS'(FLIT_BUFFER_DEPTH - 1);
  localparam logic [VC_BITS:0]      NUM_VCS_C = (VC_BITS + 1)'(NUM_VCS);
  localparam logic [VC_BITS-1:0]    LAST_VC   = VC_BITS'(NUM_VCS - 1);

  // Pointers wrap explicitly so any depth (not only powers of two) works.
  function automatic logic [PTR_BITS-1:0] ptr_inc(input logic [PTR_BITS-1:0] p);
    logic [PTR_BITS-1:0] n;
    if (p == LAST_PTR) begin
      n = '0;
    end else begin
      n = p + PTR_BITS'(1);
    end
    return n;
  endfunction

  function automatic logic [VC_BITS-1:0] vc_inc(input logic [VC_BITS-1:0] v);
    logic [VC_BITS-1:0] n;
    if (v == LAST_VC) begin
      n = '0;
    end else begin
      n = v + VC_BITS'(1);
    end
    return n;
  endfunction

  logic [FW-1:0]       r_mem    [NUM_VCS][FLIT_BUFFER_DEPTH];
  logic [PTR_BITS-1:0] r_rd_ptr [NUM_VCS];
  logic [PTR_BITS-1:0] r_wr_ptr [NUM_VCS];
  logic [CNT_BITS-1:0] r_cnt    [NUM_VCS];
  logic [VC_BITS-1:0]  r_rr;
  logic [VC_BITS:0]    r_credit;
  logic [15:0]         r_pkt_cnt;
  logic                r_overflow;

  logic                 w_in_valid;
  logic [VC_BITS-1:0]   w_in_vc;
  logic                 w_vc_legal;
  logic                 w_drop;
  logic [NUM_VCS-1:0]   w_push;
  logic [NUM_VCS-1:0]   w_pop;
  logic [NUM_VCS-1:0]   w_nonempty;
  logic [2*NUM_VCS-1:0] w_rot_dbl;
  logic                 w_found;
  logic [VC_BITS-1:0]   w_offset;
  logic [VC_BITS:0]     w_sum;
  logic [VC_BITS:0]     w_sel_sum;
  logic [VC_BITS-1:0]   w_sel;
  logic [FW-1:0]        w_head;
  logic                 w_deq_valid;
  logic                 w_pop_any;

  assign w_in_valid = flit_in[FW-1];
  assign w_in_vc    = flit_in[FLIT_DATA_WIDTH +: VC_BITS];
  assign w_vc_legal = ({1'b0, w_in_vc} < NUM_VCS_C);

  // Enqueue decode: the full check uses the pre-edge count, so a same-cycle pop never rescues a write.
  always_comb begin
    w_push = '0;
    w_drop = 1'b0;
    if (w_in_valid) begin
      if (w_vc_legal) begin
        for (int v = 0; v < NUM_VCS; v++) begin
          if (w_in_vc == VC_BITS'(v)) begin
            if (r_cnt[v] == DEPTH_C) begin
              w_drop = 1'b1;
            end else begin
              w_push[v] = 1'b1;
            end
          end else begin
            w_push[v] = 1'b0;
          end
        end
      end else begin
        w_drop = 1'b1;
      end
    end else begin
      w_drop = 1'b0;
    end
  end

  // Non-empty flags per VC.
  always_comb begin
    w_nonempty = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      w_nonempty[v] = (r_cnt[v] != '0);
    end
  end

  // Round-robin search: rotate so bit 0 is the rr VC, take the lowest set bit, rotate back.
  always_comb begin
    w_rot_dbl = {w_nonempty, w_nonempty} >> r_rr;
    w_found   = 1'b0;
    w_offset  = '0;
    for (int i = 0; i < NUM_VCS; i++) begin
      if (!w_found && w_rot_dbl[i]) begin
        w_found  = 1'b1;
        w_offset = VC_BITS'(i);
      end else begin
        w_found  = w_found;
        w_offset = w_offset;
      end
    end
    w_sum = {1'b0, r_rr} + {1'b0, w_offset};
    if (w_sum >= NUM_VCS_C) begin
      w_sel_sum = w_sum - NUM_VCS_C;
    end else begin
      w_sel_sum = w_sum;
    end
    w_sel = w_sel_sum[VC_BITS-1:0];
  end

  assign w_deq_valid = en & w_found;
  assign w_pop_any   = w_deq_valid & deq_ready;

  // Head mux and pop decode for the selected VC.
  always_comb begin
    w_head = r_mem[w_sel][r_rd_ptr[w_sel]];
    w_pop  = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      w_pop[v] = w_pop_any && (w_sel == VC_BITS'(v));
    end
    if (w_deq_valid) begin
      deq_flit = w_head;
    end else begin
      deq_flit = '0;
    end
  end

  assign deq_valid = w_deq_valid;

  // Flit storage: data need no reset because validity comes from the counts.
  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VCS; v++) begin
      if (w_push[v]) begin
        r_mem[v][r_wr_ptr[v]] <= flit_in;
      end
    end
  end

  // Per-VC pointers and fill counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        r_rd_ptr[v] <= '0;
        r_wr_ptr[v] <= '0;
        r_cnt[v]    <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VCS; v++) begin
        if (w_push[v]) begin
          r_wr_ptr[v] <= ptr_inc(r_wr_ptr[v]);
        end
        if (w_pop[v]) begin
          r_rd_ptr[v] <= ptr_inc(r_rd_ptr[v]);
        end
        case ({w_push[v], w_pop[v]})
          2'b10:   r_cnt[v] <= r_cnt[v] + CNT_BITS'(1);
          2'b01:   r_cnt[v] <= r_cnt[v] - CNT_BITS'(1);
          default: r_cnt[v] <= r_cnt[v];
        endcase
      end
    end
  end

  // Arbiter pointer, credit return, packet counter and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr       <= '0;
      r_credit   <= '0;
      r_pkt_cnt  <= 16'd0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pop_any) begin
        r_rr     <= vc_inc(w_sel);
        r_credit <= {1'b1, w_sel};
        if (w_head[FW-2]) begin
          r_pkt_cnt <= r_pkt_cnt + 16'd1;
        end
      end else begin
        r_credit <= '0;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Pack per-VC counts, VC0 in the low field.
  always_comb begin
    occupancy = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      occupancy[v*CNT_BITS +: CNT_BITS] = r_cnt[v];
    end
  end

  assign credit_out = r_credit;
  assign pkt_cnt    = r_pkt_cnt;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_pe_rx_buffer.sv
// Bench for pe_rx_buffer: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_pe_rx_buffer;

  localparam int NV    = 2;
  localparam int DW    = 64;
  localparam int PORTS = 16;
  localparam int DEPTH = 4;
  localparam int DB    = 4;
  localparam int VB    = 1;
  localparam int FW    = 2 + DW + DB + VB;
  localparam int CW    = 3;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic [FW-1:0]     flit_in;
  logic [VB:0]       credit_out;
  logic              deq_valid;
  logic              deq_ready;
  logic [FW-1:0]     deq_flit;
  logic [NV*CW-1:0]  occupancy;
  logic [15:0]       pkt_cnt;
  logic              overflow;

  int n_vec = 0;
  int n_err = 0;

  pe_rx_buffer #(
    .NUM_VCS(NV), .FLIT_DATA_WIDTH(DW),
    .NUM_USER_RECV_PORTS(PORTS), .FLIT_BUFFER_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flit_in(flit_in),
    .credit_out(credit_out), .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_flit(deq_flit), .occupancy(occupancy), .pkt_cnt(pkt_cnt),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [FW-1:0] mq [NV][$];
  int            m_rr;
  logic [15:0]   m_pkt;
  logic          m_ovf;
  logic [VB:0]   m_cred;
  int            m_pre [NV];
  int            m_sel;
  bit            m_pop;
  logic [FW-1:0] m_f;
  int            m_vc;

  // Observed traffic
  logic [DW-1:0] obs [$];
  logic [VB:0]   creds [$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_sel();
    for (int i = 0; i < NV; i++) begin
      int v;
      v = (m_rr + i) % NV;
      if (mq[v].size() > 0) return v;
    end
    return -1;
  endfunction

  function automatic logic [FW-1:0] mk(input logic tail, input logic [VB-1:0] vc, input logic [DW-1:0] d);
    return {1'b1, tail, DB'(5), vc, d};
  endfunction

  // Model update at each active edge, or immediately on reset assertion.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int v = 0; v < NV; v++) mq[v].delete();
      m_rr = 0; m_pkt = 16'd0; m_ovf = 1'b0; m_cred = '0;
    end else begin
      for (int v = 0; v < NV; v++) m_pre[v] = mq[v].size();
      m_sel = exp_sel();
      m_pop = en && deq_ready && (m_sel >= 0);
      m_cred = '0;
      if (m_pop) begin
        m_cred = {1'b1, VB'(m_sel)};
        m_f = mq[m_sel].pop_front();
        if (m_f[FW-2]) m_pkt = m_pkt + 16'd1;
        m_rr = (m_sel + 1) % NV;
      end
      if (flit_in[FW-1]) begin
        m_vc = int'(flit_in[DW +: VB]);
        if (m_vc >= NV || m_pre[m_vc] == DEPTH) m_ovf = 1'b1;
        else mq[m_vc].push_back(flit_in);
      end
    end
  end

  logic          c_ev;
  int            c_s;
  logic [FW-1:0] c_ef;
  logic [NV*CW-1:0] c_eo;

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    c_s  = exp_sel();
    c_ev = en && (c_s >= 0);
    if (c_ev) c_ef = mq[c_s][0];
    else c_ef = '0;
    for (int v = 0; v < NV; v++) c_eo[v*CW +: CW] = CW'(mq[v].size());
    chk("deq_valid", 128'(deq_valid), 128'(c_ev));
    chk("deq_flit", 128'(deq_flit), 128'(c_ef));
    chk("credit_out", 128'(credit_out), 128'(m_cred));
    chk("occupancy", 128'(occupancy), 128'(c_eo));
    chk("pkt_cnt", 128'(pkt_cnt), 128'(m_pkt));
    chk("overflow", 128'(overflow), 128'(m_ovf));
    if (deq_valid && deq_ready) obs.push_back(deq_flit[DW-1:0]);
    if (credit_out[VB]) creds.push_back(credit_out);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs.delete();
    creds.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    en = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; deq_ready = 1'b1; flit_in = '0;
    tick(); tick();

    // Single flit right after reset release
    rst_n = 1'b1;
    flit_in = mk(1'b1, 1'b0, 64'hA);
    tick();
    flit_in = '0;
    chk("s1_valid", 128'(deq_valid), 128'd1);
    chk("s1_data", 128'(deq_flit[DW-1:0]), 128'hA);
    tick();
    chk("s1_credit", 128'(credit_out), 128'd2);
    chk("s1_pkt", 128'(pkt_cnt), 128'd1);
    tick();
    chk("s1_credit_once", 128'(credit_out), 128'd0);

    // Fill vc1 to depth, fifth flit dropped, then drain
    do_reset();
    deq_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      flit_in = mk(1'b0, 1'b1, 64'h10 + 64'(i));
      tick();
    end
    flit_in = '0;
    chk("s2_occ_full", 128'(occupancy), 128'b100_000);
    chk("s2_ovf", 128'(overflow), 128'd1);
    clear_obs();
    deq_ready = 1'b1;
    repeat (6) tick();
    chk("s2_obs_n", 128'(obs.size()), 128'd4);
    chk("s2_cred_n", 128'(creds.size()), 128'd4);
    for (int i = 0; i < 4; i++) begin
      chk("s2_order", 128'(obs[i]), 128'h10 + 128'(i));
      chk("s2_cred_vc", 128'(creds[i]), 128'd3);
    end
    chk("s2_ovf_sticky", 128'(overflow), 128'd1);

    // Two VCs with three flits each alternate
    do_reset();
    deq_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      flit_in = mk(1'b0, 1'b0, 64'h20 + 64'(i)); tick();
      flit_in = mk(1'b0, 1'b1, 64'h30 + 64'(i)); tick();
    end
    flit_in = '0;
    clear_obs();
    deq_ready = 1'b1;
    repeat (8) tick();
    chk("s3_obs_n", 128'(obs.size()), 128'd6);
    chk("s3_cred_n", 128'(creds.size()), 128'd6);
    for (int i = 0; i < 6; i++) begin
      chk("s3_order", 128'(obs[i]), ((i % 2 == 0) ? 128'h20 : 128'h30) + 128'(i / 2));
      chk("s3_cred", 128'(creds[i]), 128'd2 + 128'(i % 2));
    end

    // Enable low holds the buffer
    do_reset();
    en = 1'b0;
    flit_in = mk(1'b0, 1'b0, 64'h40); tick();
    flit_in = mk(1'b1, 1'b0, 64'h41); tick();
    flit_in = '0;
    clear_obs();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s4_hold_valid", 128'(deq_valid), 128'd0);
      chk("s4_hold_cred", 128'(credit_out), 128'd0);
    end
    chk("s4_hold_occ", 128'(occupancy), 128'b000_010);
    en = 1'b1;
    repeat (4) tick();
    chk("s4_obs_n", 128'(obs.size()), 128'd2);
    chk("s4_first", 128'(obs[0]), 128'h40);
    chk("s4_second", 128'(obs[1]), 128'h41);
    chk("s4_cred_n", 128'(creds.size()), 128'd2);
    chk("s4_pkt", 128'(pkt_cnt), 128'd1);

    // Reset with flits buffered and a credit pending
    do_reset();
    deq_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      flit_in = mk(1'b0, 1'b0, 64'h50 + 64'(i));
      tick();
    end
    flit_in = '0;
    deq_ready = 1'b1;
    tick();
    deq_ready = 1'b0;
    chk("s5_pending", 128'(credit_out), 128'd2);
    chk("s5_occ3", 128'(occupancy), 128'b000_011);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s5_rst_cred", 128'(credit_out), 128'd0);
    chk("s5_rst_occ", 128'(occupancy), 128'd0);
    chk("s5_rst_valid", 128'(deq_valid), 128'd0);
    chk("s5_rst_flit", 128'(deq_flit), 128'd0);
    clear_obs();
    tick(); tick();
    rst_n = 1'b1;
    deq_ready = 1'b1;
    repeat (4) tick();
    chk("s5_no_cred", 128'(creds.size()), 128'd0);
    chk("s5_empty", 128'(occupancy), 128'd0);

    // Simultaneous enqueue/dequeue on vc0 at count 2
    do_reset();
    deq_ready = 1'b0;
    flit_in = mk(1'b0, 1'b0, 64'h60); tick();
    flit_in = mk(1'b0, 1'b0, 64'h61); tick();
    clear_obs();
    deq_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      flit_in = mk(1'b0, 1'b0, 64'h62 + 64'(i));
      tick();
      chk("s6_occ", 128'(occupancy), 128'b000_010);
    end
    flit_in = '0;
    deq_ready = 1'b0;
    tick();
    chk("s6_cred_n", 128'(creds.size()), 128'd10);
    chk("s6_obs_n", 128'(obs.size()), 128'd10);
    for (int i = 0; i < 10; i++) begin
      chk("s6_order", 128'(obs[i]), 128'h60 + 128'(i));
      chk("s6_cred", 128'(creds[i]), 128'd2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
